prbs7_checker: RTL and testbench

Serial PRBS-7 receiver/checker, the receive-side counterpart of the team's 7-bit LFSR pattern generator (polynomial x^7 + x^3 + 1).
- Consumes one received bit per enabled cycle.
- Self-synchronises its local 7-bit history to the incoming stream.
- Declares lock, then flags and counts bit errors for link/BER testing in the lab top level.

---
 rtl/prbs_pkg.sv | 19 +
 rtl/prbs7_checker.sv | 135 +++++++++++++
 tb/tb_prbs7_checker.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS-7 definitions (x^7 + x^3 + 1) used by the pattern generator and checker.
package prbs_pkg;

  localparam int PRBS_LEN = 7;
  localparam int TAP_A    = 7;
  localparam int TAP_B    = 3;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // h[1] is the most recent bit; the return value is the next bit in the sequence.
  function automatic logic prbs7_fb(input logic [PRBS_LEN:1] h);
    return h[TAP_A] ^ h[TAP_B];
  endfunction

endpackage

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS-7 receiver: seeds, syncs, locks, then flags and counts bit errors.
// Optional `PRBS_CHK_BITCNT_EN adds bit_count, the number of bits compared while locked.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             data_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
`ifdef PRBS_CHK_BITCNT_EN
  output logic [CNT_W-1:0] bit_count,
`endif
  output logic [CNT_W-1:0] err_count
);

  localparam int SEED_W  = $clog2(PRBS_LEN);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  state_t              state_q, state_d;
  logic [PRBS_LEN:1]   h_q, h_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                err_d;
  logic                exp_bit;
  logic                mismatch;
  logic [PRBS_LEN:1]   h_shift;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    h_d      = h_q;
    seed_d   = seed_q;
    match_d  = match_q;
    miss_d   = miss_q;
    err_d    = 1'b0;
    exp_bit  = prbs7_fb(h_q);
    mismatch = data_in ^ exp_bit;
    h_shift  = {h_q[PRBS_LEN-1:1], data_in};

    if (en) begin
      unique case (state_q)
        SEED: begin
          h_d    = h_shift;
          seed_d = seed_q + SEED_W'(1);
          if (seed_q == SEED_W'(PRBS_LEN - 1)) begin
            seed_d = '0;
            // An all-zero window is the one state the LFSR can never be in.
            if (h_shift != '0) begin
              state_d = SYNC;
              match_d = '0;
            end
          end
        end
        SYNC: begin
          h_d = h_shift;
          if (!mismatch) begin
            match_d = match_q + MATCH_W'(1);
            if (match_d == MATCH_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel on the predicted bit so a single line error does not corrupt history.
          h_d = {h_q[PRBS_LEN-1:1], exp_bit};
          if (mismatch) begin
            err_d  = 1'b1;
            miss_d = miss_q + MISS_W'(1);
            if (miss_d == MISS_W'(LOSS_CNT)) begin
              state_d = SEED;
              seed_d  = '0;
              h_d     = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q <= SEED;
      h_q     <= '0;
      seed_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      seed_q  <= seed_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      locked  <= (state_d == LOCKED);
      err     <= err_d;
    end
  end

  // Saturating error counter; clr_cnt wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst || clr_cnt) begin
      err_count <= '0;
    end else if (err_d && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  always_ff @(posedge clk) begin
    if (!rst || clr_cnt) begin
      bit_count <= '0;
    end else if (en && (state_q == LOCKED) && (bit_count != '1)) begin
      bit_count <= bit_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_prbs7_checker.sv
// Self-checking bench for prbs7_checker: reset table, directed lock/error/loss sequences,
// and a randomized run against a queue-based reference model.
module tb_prbs7_checker;

  localparam int LOCK = 16;
  localparam int LOSS = 4;
  localparam int W    = 16;
  localparam int W4   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic data_in = 1'b0;
  logic clr_cnt = 1'b0;
  logic locked, err, locked4, err4;
  logic [W-1:0]  err_count;
  logic [W4-1:0] err_count4;
`ifdef PRBS_CHK_BITCNT_EN
  logic [W-1:0]  bit_count;
  logic [W4-1:0] bit_count4;
`endif

  always #5 clk = ~clk;

  prbs7_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
    .locked(locked), .err(err),
`ifdef PRBS_CHK_BITCNT_EN
    .bit_count(bit_count),
`endif
    .err_count(err_count)
  );

  prbs7_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(W4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
    .locked(locked4), .err(err4),
`ifdef PRBS_CHK_BITCNT_EN
    .bit_count(bit_count4),
`endif
    .err_count(err_count4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Generator sequence: seq[0..6] is the reset history (h7..h1 = 0000001), then
  // seq[n] = seq[n-7] ^ seq[n-3]. Transmitted bit p is seq[p+7]; period 127.
  bit seq[134];
  int pos;

  function automatic bit gbit(input int p);
    return seq[(p % 127) + 7];
  endfunction

  // Reference model: receive history as a queue (front = oldest = h7, back = h1).
  bit m_hist[$];
  int m_mode;            // 0 seeding, 1 syncing, 2 locked
  int m_seen, m_run, m_miss, m_errs, m_bits;
  bit m_err;

  function automatic void model_reset();
    m_hist.delete();
    repeat (7) m_hist.push_back(1'b0);
    m_mode = 0;
    m_seen = 0;
    m_run  = 0;
    m_miss = 0;
    m_errs = 0;
    m_bits = 0;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit d, input bit c);
    bit x;
    int nz;
    m_err = 1'b0;
    if (!r) begin
      model_reset();
    end else begin
      if (e) begin
        x = m_hist[0] ^ m_hist[4];
        if (m_mode == 0) begin
          m_hist.push_back(d);
          void'(m_hist.pop_front());
          m_seen++;
          if (m_seen == 7) begin
            m_seen = 0;
            nz = 0;
            foreach (m_hist[i]) nz += int'(m_hist[i]);
            if (nz != 0) begin
              m_mode = 1;
              m_run  = 0;
            end
          end
        end else if (m_mode == 1) begin
          m_hist.push_back(d);
          void'(m_hist.pop_front());
          if (d == x) begin
            m_run++;
            if (m_run == LOCK) begin
              m_mode = 2;
              m_miss = 0;
            end
          end else begin
            m_run = 0;
          end
        end else begin
          m_bits++;
          m_hist.push_back(x);
          void'(m_hist.pop_front());
          if (d != x) begin
            m_err = 1'b1;
            m_errs++;
            m_miss++;
            if (m_miss == LOSS) begin
              m_hist.delete();
              repeat (7) m_hist.push_back(1'b0);
              m_mode = 0;
              m_seen = 0;
            end
          end else begin
            m_miss = 0;
          end
        end
      end
      if (c) begin
        m_errs = 0;
        m_bits = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("locked", locked, 32'(m_mode == 2));
    check("err", err, 32'(m_err));
    check("err_count", err_count, sat(m_errs, W));
    check("locked4", locked4, 32'(m_mode == 2));
    check("err4", err4, 32'(m_err));
    check("err_count4", err_count4, sat(m_errs, W4));
`ifdef PRBS_CHK_BITCNT_EN
    check("bit_count", bit_count, sat(m_bits, W));
    check("bit_count4", bit_count4, sat(m_bits, W4));
`endif
  endtask

  task automatic step(input bit r, input bit e, input bit d, input bit c);
    @(negedge clk);
    rst = r;
    en = e;
    data_in = d;
    clr_cnt = c;
    @(posedge clk);
    model_step(r, e, d, c);
    #1;
    compare_all();
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, gbit(pos), 1'b0);
      pos++;
    end
  endtask

  task automatic send_err(input bit c = 1'b0);
    step(1'b1, 1'b1, ~gbit(pos), c);
    pos++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    pos = 0;
  endtask

  typedef struct {
    bit r, e, d, c;
    bit xl, xe;
    int xc;
  } vec_t;

  vec_t vt[4];
  int   err_seen;
  int   burst;

  initial begin
    for (int n = 0; n < 6; n++) seq[n] = 1'b0;
    seq[6] = 1'b1;
    for (int n = 7; n < 134; n++) seq[n] = seq[n-7] ^ seq[n-3];
    model_reset();
    m_err = 1'b0;
    pos = 0;

    // 1. Reset table: random activity while held in reset, then idle after release.
    vt[0] = '{r:1'b0, e:1'b0, d:1'b0, c:1'b0, xl:1'b0, xe:1'b0, xc:0};
    vt[1] = '{r:1'b0, e:1'b0, d:1'b0, c:1'b0, xl:1'b0, xe:1'b0, xc:0};
    vt[2] = '{r:1'b1, e:1'b0, d:1'b0, c:1'b0, xl:1'b0, xe:1'b0, xc:0};
    vt[3] = '{r:1'b1, e:1'b0, d:1'b1, c:1'b1, xl:1'b0, xe:1'b0, xc:0};
    vt[0].e = 1'($urandom); vt[0].d = 1'($urandom);
    vt[1].e = 1'($urandom); vt[1].d = 1'($urandom);
    foreach (vt[i]) begin
      step(vt[i].r, vt[i].e, vt[i].d, vt[i].c);
      check("tbl_locked", locked, 32'(vt[i].xl));
      check("tbl_err", err, 32'(vt[i].xe));
      check("tbl_err_count", err_count, vt[i].xc);
    end

    // 2. Clean lock from the generator's reset state: locked rises after bit 23.
    do_reset();
    for (int i = 1; i <= 23; i++) begin
      send_clean(1);
      if (i == 22) check("pre_lock_22", locked, 0);
      if (i == 23) check("lock_at_23", locked, 1);
    end
    err_seen = 0;
    for (int i = 0; i < 200; i++) begin
      send_clean(1);
      err_seen += int'(err);
    end
    check("clean_no_err", err_seen, 0);

    // 3. Single line error while locked.
    send_err();
    check("single_err_pulse", err, 1);
    check("single_err_count", err_count, 1);
    send_clean(1);
    check("single_err_end", err, 0);
    check("single_still_locked", locked, 1);
    err_seen = 0;
    for (int i = 0; i < 49; i++) begin
      send_clean(1);
      err_seen += int'(err);
    end
    check("post_single_no_err", err_seen, 0);

    // 4. Four consecutive errors drop lock; 23 clean bits relock; reset aborts.
    for (int k = 1; k <= 4; k++) begin
      send_err();
      if (k == 3) check("loss_still_locked_3", locked, 1);
    end
    check("loss_unlocked", locked, 0);
    check("loss_err_count", err_count, 5);
    send_clean(22);
    check("relock_pre", locked, 0);
    send_clean(1);
    check("relock", locked, 1);
    send_clean(10);
    step(1'b0, 1'b1, gbit(pos), 1'b0);
    check("midreset_locked", locked, 0);
    check("midreset_err_count", err_count, 0);
    check("midreset_err", err, 0);

    // 5. All-zero input never leaves seeding; gapped en locks at the same bit index.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("zero_locked", locked, 0);
    check("zero_err_count", err_count, 0);
    do_reset();
    for (int i = 1; i <= 23; i++) begin
      send_clean(1);
      if (i == 22) check("gap_pre_lock", locked, 0);
      if (i == 23) check("gap_lock_at_23", locked, 1);
      if (i < 23) step(1'b1, 1'b0, 1'($urandom), 1'b0);
    end

    // 6. Counter clear priority and saturation.
    for (int k = 0; k < 5; k++) begin
      send_err();
      send_clean(1);
    end
    check("cnt_five", err_count, 5);
    send_err(1'b1);
    check("clr_over_inc", err_count, 0);
    check("clr_err_pulse", err, 1);
    send_clean(1);
    for (int k = 0; k < 20; k++) begin
      send_err();
      send_clean(1);
    end
    check("cnt_twenty", err_count, 20);
    check("cnt4_saturated", err_count4, 15);
    check("sat_still_locked", locked, 1);
`ifdef PRBS_CHK_BITCNT_EN
    check("bitcnt_locked_bits", bit_count, 41);
`endif

    // 7. Randomized run: random gaps, line errors, bursts, clears and rare resets.
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, e, c, flip, d;
      r = ($urandom_range(0, 599) != 0);
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 149) == 0);
      if (burst == 0 && $urandom_range(0, 249) == 0) burst = $urandom_range(2, 6);
      flip = (burst != 0) || ($urandom_range(0, 39) == 0);
      if (!r) begin
        step(1'b0, e, 1'($urandom), c);
        pos = 0;
      end else if (e) begin
        d = gbit(pos) ^ flip;
        if (burst != 0) burst--;
        step(1'b1, 1'b1, d, c);
        pos++;
      end else begin
        step(1'b1, 1'b0, 1'($urandom), c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
